// File: rtl/aes_pkg.sv
// Constants and ShiftRows index maps shared by the AES byte-stream blocks.
// State bytes are column-major: idx = row + 4*col.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;

  // Source index for output idx of InvShiftRows: row r is rotated right by r columns.
  function automatic logic [3:0] inv_sr_idx(input logic [3:0] idx);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row     = idx[1:0];
    col     = idx[3:2];
    src_col = col - row;
    return {src_col, row};
  endfunction

  // Source index for output idx of forward ShiftRows: row r is rotated left by r columns.
  function automatic logic [3:0] fwd_sr_idx(input logic [3:0] idx);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row     = idx[1:0];
    col     = idx[3:2];
    src_col = col + row;
    return {src_col, row};
  endfunction

endpackage

// File: rtl/sr_bank.sv
// 16x8 register bank: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module sr_bank
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [BLOCK_BYTES];

  // Byte write into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inv_shiftrows_stream.sv
// Streaming AES InvShiftRows over a byte stream using two ping-pong 16-byte banks.
// Sticky done once BLOCK_COUNT whole blocks have been emitted.
module inv_shiftrows_stream
  import aes_pkg::*;
#(
  parameter int BLOCK_COUNT = 16384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       done
);

  localparam int CNT_W = $clog2(BLOCK_COUNT + 1);
  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_COUNT);

  logic [1:0]       full;
  logic [1:0]       full_next;
  logic             wr_bank;
  logic             rd_bank;
  logic [3:0]       wr_idx;
  logic [3:0]       rd_idx;
  logic [CNT_W-1:0] blk_cnt;

  logic       in_fire;
  logic       out_fire;
  logic       in_last;
  logic       out_last;
  logic       we0;
  logic       we1;
  logic [3:0] raddr;
  logic [7:0] rdata0;
  logic [7:0] rdata1;

  // Handshakes, bank selects and full-flag next state.
  always_comb begin
    s_ready  = !full[wr_bank] && !done;
    m_valid  = full[rd_bank];
    in_fire  = s_valid && s_ready;
    out_fire = m_valid && m_ready;
    in_last  = in_fire && (wr_idx == LAST_IDX);
    out_last = out_fire && (rd_idx == LAST_IDX);
    we0      = in_fire && (wr_bank == 1'b0);
    we1      = in_fire && (wr_bank == 1'b1);
    raddr    = inv_sr_idx(rd_idx);
    if (rd_bank) begin
      m_data = rdata1;
    end else begin
      m_data = rdata0;
    end
    // Set and clear always target different banks, so both apply.
    full_next = full;
    if (in_last) begin
      full_next[wr_bank] = 1'b1;
    end else begin
      full_next = full_next;
    end
    if (out_last) begin
      full_next[rd_bank] = 1'b0;
    end else begin
      full_next = full_next;
    end
  end

  sr_bank u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wr_idx),
    .wdata (s_data),
    .raddr (raddr),
    .rdata (rdata0)
  );

  sr_bank u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wr_idx),
    .wdata (s_data),
    .raddr (raddr),
    .rdata (rdata1)
  );

  // Write/read pointers, full flags, block counter and sticky done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= 4'd0;
      rd_idx  <= 4'd0;
      blk_cnt <= '0;
      done    <= 1'b0;
    end else begin
      full <= full_next;
      if (in_fire) begin
        wr_idx <= wr_idx + 4'd1;
        if (in_last) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (out_fire) begin
        rd_idx <= rd_idx + 4'd1;
        if (out_last) begin
          rd_bank <= ~rd_bank;
          if (blk_cnt != CNT_MAX) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
          end
          // done becomes visible the cycle after the final byte leaves.
          if (blk_cnt == CNT_MAX - CNT_W'(1)) begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
// Randomized self-checking bench for inv_shiftrows_stream against a queue-based
// model of the byte permutation, buffering and done behaviour.
module tb_inv_shiftrows_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, m_valid, m_ready, done;
  logic [7:0] s_data, m_data;

  logic       b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_done;
  logic [7:0] b_s_data, b_m_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inv_shiftrows_stream dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .done(done));

  inv_shiftrows_stream #(.BLOCK_COUNT(4)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .done(b_done));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output position k takes input byte at row r, column (c - r) mod 4.
  function automatic int inv_src(input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return r + 4 * ((c - r + 4) % 4);
  endfunction

  function automatic int fwd_src(input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return r + 4 * ((c + r) % 4);
  endfunction

  byte unsigned src_q[$];
  byte unsigned part[$];
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  int emitted_blk = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int blk_done_cyc = 0;
  int lat = 0;
  bit prev_mv = 1'b0;

  // Reference model and per-cycle compare for the default-size instance.
  always @(negedge clk) begin
    int bufd;
    cyc++;
    if (rst) begin
      part.delete();
      exp_q.delete();
      emitted_blk = 0;
      prev_mv = 1'b0;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_done", done, 0);
    end else begin
      bufd = (exp_q.size() + 15) / 16;
      chk("m_valid", m_valid, exp_q.size() > 0);
      chk("s_ready", s_ready, bufd < 2);
      chk("done", done, 0);
      if (m_valid && !prev_mv) lat = cyc - blk_done_cyc;
      prev_mv = m_valid;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
          if (exp_q.size() % 16 == 0) emitted_blk++;
        end
        got_q.push_back(m_data);
      end
      if (s_valid && s_ready) begin
        part.push_back(s_data);
        acc_cnt++;
        if (part.size() == 16) begin
          for (int k = 0; k < 16; k++) exp_q.push_back(part[inv_src(k)]);
          part.delete();
          blk_done_cyc = cyc;
        end
      end
    end
  end

  bit b_run = 1'b0;
  int b_acc = 0;
  int b_out = 0;
  int b_emit = 0;

  // Compare for the four-block instance: input byte n carries value n.
  always @(negedge clk) begin
    if (!rst && b_run) begin
      chk("b_done", b_done, b_emit >= 4);
      if (b_emit >= 4) chk("b_s_ready_after_done", b_s_ready, 0);
      if (b_m_valid && b_m_ready) begin
        chk("b_m_data", b_m_data, ((b_out / 16) * 16 + inv_src(b_out % 16)) % 256);
        b_out++;
        if (b_out % 16 == 0) b_emit++;
      end
      if (b_s_valid && b_s_ready) b_acc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic run(input int max, input int pv, input int pr, input bit must_finish);
    int n;
    bit fire;
    n = 0;
    while (n < max && (src_q.size() > 0 || s_valid || exp_q.size() > 0)) begin
      if (!s_valid && src_q.size() > 0 && $urandom_range(99) < pv) begin
        s_valid = 1'b1;
        s_data = src_q.pop_front();
      end
      m_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      fire = s_valid && s_ready;
      step();
      if (fire) s_valid = 1'b0;
      n++;
    end
    if (must_finish && n >= max) chk("timeout", n, -1);
  endtask

  byte unsigned ref33[16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                              8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

  initial begin
    byte unsigned blk[16];
    byte unsigned orig[$];
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = 8'h00; b_m_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Counting pattern, back to back.
    got_q.delete(); lat = 0;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    run(200, 100, 100, 1'b1);
    chk("cnt_len", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("cnt_literal", got_q[i], ref33[i]);
    chk("latency", lat, 1);

    // Round trip through the forward map.
    got_q.delete(); orig.delete();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
        orig.push_back(blk[k]);
        src_q.push_back(blk[fwd_src(k)]);
      end
    end
    run(500, 80, 80, 1'b1);
    chk("rt_len", got_q.size(), 64);
    for (int i = 0; i < 64 && i < got_q.size(); i++) chk("round_trip", got_q[i], orig[i]);

    // Backpressure: both banks fill, then drain.
    do_reset();
    acc_cnt = 0; got_q.delete();
    for (int i = 0; i < 40; i++) src_q.push_back(8'(i));
    run(60, 100, 0, 1'b0);
    chk("bp_accepted", acc_cnt, 32);
    chk("bp_s_ready", s_ready, 0);
    run(300, 100, 100, 1'b1);
    chk("bp_accepted_all", acc_cnt, 40);
    chk("bp_out_len", got_q.size(), 32);
    if (got_q.size() == 32) begin
      chk("bp_byte1", got_q[1], 13);
      chk("bp_byte17", got_q[17], 29);
    end

    // Reset mid-block, then the counting pattern again.
    do_reset();
    for (int i = 0; i < 7; i++) src_q.push_back(8'(8'hA0 + i));
    run(50, 100, 100, 1'b1);
    do_reset();
    got_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    run(200, 100, 100, 1'b1);
    chk("rst_mid_len", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("rst_mid_literal", got_q[i], ref33[i]);

    // Long throttled random stream.
    do_reset();
    got_q.delete();
    for (int i = 0; i < 16000; i++) src_q.push_back(8'($urandom));
    run(60000, 70, 70, 1'b1);
    chk("rand_len", got_q.size(), 16000);
    chk("rand_blocks", emitted_blk, 1000);

    // Four-block instance: done and input shutoff.
    b_run = 1'b1;
    b_m_ready = 1'b1;
    for (int n = 0; n < 120; n++) begin
      b_s_valid = (b_acc < 64);
      b_s_data = 8'(b_acc);
      step();
    end
    b_s_valid = 1'b0;
    step();
    chk("b_accepted", b_acc, 64);
    chk("b_emitted", b_out, 64);
    chk("b_done_final", b_done, 1);
    chk("b_s_ready_final", b_s_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
